// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared widths, control encodings and the WB-stage entry type
package mem_wb_pkg;

    localparam int reg_bus      = 32;
    localparam int reg_addr_bus = 5;
    localparam int stall_bus    = 6;
    localparam int stall_mem    = 4;
    localparam int stall_wb     = 5;

    localparam logic rst_enable   = 1'b0;
    localparam logic write_enable = 1'b1;
    localparam logic [reg_bus-1:0] zero_word = '0;

    typedef struct packed {
        logic [reg_addr_bus-1:0] wd;
        logic                    wreg;
        logic [reg_bus-1:0]      wdata;
        logic                    whilo;
        logic [reg_bus-1:0]      hi;
        logic [reg_bus-1:0]      lo;
        logic                    llbit_we;
        logic                    llbit_value;
    } wb_entry_t;

    localparam wb_entry_t wb_bubble = '0;

endpackage

// File: rtl/mem_wb_if.sv
// rtl/mem_wb_if.sv - MEM-side inputs and WB-side outputs of the MEM/WB register
interface mem_wb_if;
    import mem_wb_pkg::*;

    logic [stall_bus-1:0]    stall;
    logic                    flush;
    logic [reg_addr_bus-1:0] mem_wd;
    logic                    mem_wreg;
    logic [reg_bus-1:0]      mem_wdata;
    logic                    mem_whilo;
    logic [reg_bus-1:0]      mem_hi;
    logic [reg_bus-1:0]      mem_lo;
    logic                    mem_LLbit_we;
    logic                    mem_LLbit_value;

    logic [reg_addr_bus-1:0] wb_wd;
    logic                    wb_wreg;
    logic [reg_bus-1:0]      wb_wdata;
    logic                    wb_whilo;
    logic [reg_bus-1:0]      wb_hi;
    logic [reg_bus-1:0]      wb_lo;
    logic                    LLbit_o;
    logic [reg_bus-1:0]      wb_count;

    modport slave (
        input  stall, flush, mem_wd, mem_wreg, mem_wdata, mem_whilo,
               mem_hi, mem_lo, mem_LLbit_we, mem_LLbit_value,
        output wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
               LLbit_o, wb_count
    );

    modport master (
        output stall, flush, mem_wd, mem_wreg, mem_wdata, mem_whilo,
               mem_hi, mem_lo, mem_LLbit_we, mem_LLbit_value,
        input  wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
               LLbit_o, wb_count
    );

endinterface

// File: rtl/mem_wb_llbit_reg.sv
// rtl/mem_wb_llbit_reg.sv - LL/SC link bit; cleared by reset or exception flush
module mem_wb_llbit_reg
    import mem_wb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic we,
    input  logic LLbit_i,
    output logic LLbit_o
);

    always_ff @(posedge clk) begin
        if (rst == rst_enable) begin
            LLbit_o <= 1'b0;
        end else if (flush) begin
            LLbit_o <= 1'b0;
        end else if (we == write_enable) begin
            LLbit_o <= LLbit_i;
        end
    end

endmodule

// File: rtl/mem_wb.sv
// rtl/mem_wb.sv - MEM/WB pipeline register with link bit forwarding and commit counter
module mem_wb
    import mem_wb_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    mem_wb_if.slave  bus
);

    wb_entry_t          wb_q;
    wb_entry_t          mem_entry;
    logic               llbit_q;
    logic [reg_bus-1:0] count_q;

    always_comb begin
        mem_entry             = wb_bubble;
        mem_entry.wd          = bus.mem_wd;
        mem_entry.wreg        = bus.mem_wreg;
        mem_entry.wdata       = bus.mem_wdata;
        mem_entry.whilo       = bus.mem_whilo;
        mem_entry.hi          = bus.mem_hi;
        mem_entry.lo          = bus.mem_lo;
        mem_entry.llbit_we    = bus.mem_LLbit_we;
        mem_entry.llbit_value = bus.mem_LLbit_value;
    end

    // MEM held while WB drains: WB must see a bubble, not a duplicate of the held entry.
    always_ff @(posedge clk) begin
        if (rst == rst_enable) begin
            wb_q <= wb_bubble;
        end else if (bus.flush) begin
            wb_q <= wb_bubble;
        end else if (bus.stall[stall_mem] && !bus.stall[stall_wb]) begin
            wb_q <= wb_bubble;
        end else if (!bus.stall[stall_mem]) begin
            wb_q <= mem_entry;
        end
    end

    // The regfile commits the presented entry on every edge, stalled or not, so count it.
    always_ff @(posedge clk) begin
        if (rst == rst_enable) begin
            count_q <= zero_word;
        end else if (wb_q.wreg == write_enable && wb_q.wd != '0) begin
            count_q <= count_q + 1'b1;
        end
    end

    mem_wb_llbit_reg u_llbit_reg (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.flush),
        .we      (wb_q.llbit_we),
        .LLbit_i (wb_q.llbit_value),
        .LLbit_o (llbit_q)
    );

    assign bus.wb_wd    = wb_q.wd;
    assign bus.wb_wreg  = wb_q.wreg;
    assign bus.wb_wdata = wb_q.wdata;
    assign bus.wb_whilo = wb_q.whilo;
    assign bus.wb_hi    = wb_q.hi;
    assign bus.wb_lo    = wb_q.lo;
    assign bus.wb_count = count_q;

    assign bus.LLbit_o = bus.flush ? 1'b0 :
                         (wb_q.llbit_we ? wb_q.llbit_value : llbit_q);

endmodule

// File: doc/mem_wb.md
# mem_wb

MEM/WB pipeline register of the MIPS32 five-stage core, with the LL/SC link bit held locally. It latches MEM-stage results and drives the register file write port (`we`/`waddr`/`wdata`) and the HI/LO write port directly. It obeys the global stall vector and exception flush, and returns the forwarded LLbit to MEM for `SC` evaluation. A retirement counter of committed GPR writes is kept for debug.

## Interface
- No parameters; widths come from `defines.v`: `RegBus` = 32, `RegAddrBus` = 5, `StallBus` = 6.
- `clk` in 1 — single core clock, all state on posedge.
- `rst` in 1 — reset is synchronous and active-low; asserted when `rst == RstEnable` (1'b0).
- `stall` in 6 — global stall vector; bit 4 = MEM held, bit 5 = WB held.
- `flush` in 1 — exception/ERET flush, one-cycle pulse.
- `mem_wd` in 5 — destination GPR.
- `mem_wreg` in 1 — GPR write enable.
- `mem_wdata` in 32 — GPR write data.
- `mem_whilo` in 1 — HI/LO write enable.
- `mem_hi`, `mem_lo` in 32 each — HI/LO write data.
- `mem_LLbit_we` in 1 — LLbit write enable (LL, or SC success).
- `mem_LLbit_value` in 1 — LLbit write value.
- `wb_wd` out 5, `wb_wreg` out 1, `wb_wdata` out 32 — to regfile `waddr`/`we`/`wdata`.
- `wb_whilo` out 1, `wb_hi` out 32, `wb_lo` out 32 — to the HI/LO register.
- `LLbit_o` out 1 — forwarded link bit to MEM.
- `wb_count` out 32 — committed GPR-write counter.

## Operation
- Pipeline register update, evaluated each posedge in this priority order:
  1. `rst == RstEnable`: all `wb_*` outputs 0, LLbit register 0, `wb_count` 0.
  2. `flush == 1`: all `wb_*` outputs 0 (bubble); LLbit register cleared to 0.
  3. `stall[4] == 1 && stall[5] == 0`: bubble inserted; all `wb_*` outputs 0.
  4. `stall[4] == 0`: capture all `mem_*` inputs into the `wb_*` outputs.
  5. Otherwise (both stalls set): hold all `wb_*` outputs.
- Registered WB-side LLbit fields `wb_LLbit_we`/`wb_LLbit_value` (internal) follow the same rules as the other `wb_*` fields.
- LLbit register: on a posedge with no reset and no flush, if `wb_LLbit_we` then load `wb_LLbit_value`, else hold.
- `LLbit_o` (combinational):
  - 0 if `flush`;
  - else `wb_LLbit_value` if `wb_LLbit_we`;
  - else the LLbit register.
- `wb_count` increments by 1 (mod 2^32, wraps to 0) on each posedge where the current `wb_wreg == 1`, `wb_wd != 0`, and `rst` is deasserted. Stall or flush does not suppress the increment of the entry currently presented, since the regfile commits that write on the same edge.
- A write to `$0` is passed through unchanged; the regfile discards it. Such writes are not counted.

## Timing
- Latency: MEM inputs appear on `wb_*` 1 cycle after the capturing edge. The regfile commits on the next edge; its internal write-to-read bypass covers same-cycle reads by ID.
- Reset and flush both take effect at the edge. The outputs read 0 in the following cycle.
- Simultaneous `flush` and `stall`: flush wins.
- Simultaneous flush and a WB-stage `wb_LLbit_we`: the LLbit register ends at 0.
- Reset mid-stall: state clears; no held entry survives.
- `LLbit_o` has zero latency relative to `wb_LLbit_*` and `flush`.

## Structure
- Stall bit positions, `RstEnable`, `WriteEnable`, `ZeroWord`, and bus widths live in `defines.v`; no new constants are added here.
- One natural sub-module: `LLbit_reg` (clk, rst, flush, we, LLbit_i, LLbit_o register). `mem_wb` keeps the forwarding mux outside it.

## Test plan
- **Reset:** hold `rst` = 0 for 2 cycles with `mem_wreg` = 1, `mem_wd` = 5 → all `wb_*` = 0, `LLbit_o` = 0, `wb_count` = 0.
- **Pass-through:** `mem_wd` = 3, `mem_wreg` = 1, `mem_wdata` = 0xDEADBEEF, stall = 0 → next cycle `wb_wd` = 3, `wb_wdata` = 0xDEADBEEF. One edge later `wb_count` = 1.
- **Stall:**
  - `stall` = 6'b011111 → `wb_*` becomes 0.
  - `stall` = 6'b111111 → previous `wb_*` held for 3 cycles.
  - An entry held with `wb_wd` = 4 and `wb_wreg` = 1 increments `wb_count` every held cycle.
- **LL/SC:**
  - LL captured with `mem_LLbit_we` = 1, value = 1 → `LLbit_o` = 1 combinationally in WB, register = 1 one edge later.
  - `flush` pulse → `LLbit_o` = 0 immediately, register = 0 after the edge.
- **Flush priority:** `flush` = 1 with `stall` = 6'b011111 and valid MEM inputs → `wb_*` = 0, LLbit register = 0.
- **Counter wrap and `$0` filter:**
  - Preload `wb_count` to 0xFFFFFFFF via repeated writes or force; one more valid write → 0.
  - Write to `wb_wd` = 0 → count unchanged.
